// File: rtl/rs_pkg.sv
// Shared types, default sizes and GF(2^m) multiply-by-alpha helper for the
// Reed-Solomon syndrome engine.
package rs_pkg;

  localparam int unsigned DEF_SYM_W = 8;
  localparam int unsigned DEF_NSYN  = 32;
  localparam int unsigned MAX_W     = 16;
  localparam int unsigned EXT_W     = MAX_W + 1;
  localparam int unsigned IDX_W     = $clog2(EXT_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Multiply a w-bit field element by x: shift left, fold in the polynomial
  // when the top bit falls out; result is masked back to w bits.
  function automatic logic [EXT_W-1:0] mul_alpha(input logic [EXT_W-1:0] a,
                                                  input logic [EXT_W-1:0] poly,
                                                  input int unsigned w);
    logic [EXT_W-1:0] mask;
    mask = EXT_W'((32'd1 << w) - 32'd1);
    return ((a << 1) ^ (a[IDX_W'(w - 1)] ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/rs_syndrome_engine_gf_mul.sv
// Combinational GF(2^SYM_W) multiplier, MSB-first shift-and-add over b.
module gf_mul
  import rs_pkg::*;
#(
  parameter int unsigned SYM_W = DEF_SYM_W
) (
  input  logic [SYM_W-1:0] a,
  input  logic [SYM_W-1:0] b,
  input  logic [SYM_W:0]   prim_poly,
  output logic [SYM_W-1:0] y
);

  logic [SYM_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = int'(SYM_W) - 1; i >= 0; i--) begin
      acc = SYM_W'(mul_alpha(EXT_W'(acc), EXT_W'(prim_poly), SYM_W)) ^ (b[i] ? a : '0);
    end
    y = acc;
  end

endmodule

// File: rtl/rs_syndrome_engine.sv
// Reed-Solomon syndrome engine: precomputes evaluation roots, then folds a
// symbol stream into up to NSYN syndromes with Horner updates.
module rs_syndrome_engine
  import rs_pkg::*;
#(
  parameter int unsigned SYM_W = DEF_SYM_W,
  parameter int unsigned NSYN  = DEF_NSYN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SYM_W:0]              cfg_prim_poly,
  input  logic [SYM_W-1:0]            cfg_first_root,
  input  logic [SYM_W-1:0]            cfg_block_len,
  input  logic [$clog2(NSYN+1)-1:0]   cfg_nsyn,
  input  logic                        start,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SYM_W-1:0]            in_data,
  input  logic                        in_last,
  input  logic [$clog2(NSYN)-1:0]     syn_rd_idx,
  output logic [SYM_W-1:0]            syn_rd_data,
  output logic                        done,
  output logic                        error_free,
  output logic                        len_err
);

  localparam int unsigned NW = $clog2(NSYN + 1);
  localparam int unsigned CW = SYM_W + 1;

  state_t           state;
  logic [SYM_W:0]   poly_q;
  logic [SYM_W-1:0] fr_q;
  logic [SYM_W-1:0] len_q;
  logic [NW-1:0]    nsyn_q;
  logic [NW-1:0]    prep_idx;
  logic [CW-1:0]    cnt;

  logic [SYM_W-1:0] syn      [NSYN];
  logic [SYM_W-1:0] root     [NSYN];
  logic [SYM_W-1:0] root_nxt [NSYN];
  logic [SYM_W-1:0] prod     [NSYN];
  logic [SYM_W-1:0] syn_nxt  [NSYN];

  logic [NW-1:0]    nsyn_eff_c;
  logic [SYM_W-1:0] len_eff_c;
  logic [CW-1:0]    cnt_inc;
  logic             xfer;
  logic             hit_len;
  logic             term;
  logic             len_bad;
  logic             all_zero;

  // Configuration decode: zero or oversize counts mean "all", zero length means 2^m-1
  always_comb begin
    nsyn_eff_c = cfg_nsyn;
    if (cfg_nsyn == '0 || cfg_nsyn > NW'(NSYN)) nsyn_eff_c = NW'(NSYN);
    len_eff_c = (cfg_block_len == '0) ? '1 : cfg_block_len;
  end

  for (genvar g = 0; g < int'(NSYN); g++) begin : g_lane
    gf_mul #(.SYM_W(SYM_W)) u_mul (
      .a         (syn[g]),
      .b         (root[g]),
      .prim_poly (poly_q),
      .y         (prod[g])
    );
    if (g == 0) begin : g_first
      assign root_nxt[g] = fr_q;
    end else begin : g_next
      assign root_nxt[g] = SYM_W'(mul_alpha(EXT_W'(root[g-1]), EXT_W'(poly_q), SYM_W));
    end
  end

  // Next syndromes, zero check and length classification for the current symbol
  always_comb begin
    xfer     = in_valid && in_ready;
    cnt_inc  = cnt + CW'(1);
    hit_len  = (cnt_inc == CW'(len_q));
    term     = in_last || hit_len;
    len_bad  = in_last != hit_len;
    all_zero = 1'b1;
    for (int i = 0; i < int'(NSYN); i++) begin
      syn_nxt[i] = '0;
      if (NW'(i) < nsyn_q) syn_nxt[i] = prod[i] ^ in_data;
      if (syn_nxt[i] != '0) all_zero = 1'b0;
    end
  end

  always_comb begin
    syn_rd_data = '0;
    if (NW'(syn_rd_idx) < nsyn_q) syn_rd_data = syn[syn_rd_idx];
  end

  // Control FSM; the done cycle is spent in RUN so a coincident start is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      done       <= 1'b0;
      error_free <= 1'b0;
      len_err    <= 1'b0;
      poly_q     <= '0;
      fr_q       <= '0;
      len_q      <= '0;
      nsyn_q     <= '0;
      prep_idx   <= '0;
      cnt        <= '0;
      for (int i = 0; i < int'(NSYN); i++) begin
        syn[i]  <= '0;
        root[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            poly_q     <= cfg_prim_poly;
            fr_q       <= cfg_first_root;
            len_q      <= len_eff_c;
            nsyn_q     <= nsyn_eff_c;
            prep_idx   <= '0;
            cnt        <= '0;
            error_free <= 1'b0;
            len_err    <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_PREP;
            for (int i = 0; i < int'(NSYN); i++) begin
              syn[i]  <= '0;
              root[i] <= '0;
            end
          end
        end
        ST_PREP: begin
          for (int i = 0; i < int'(NSYN); i++) begin
            if (NW'(i) == prep_idx) root[i] <= root_nxt[i];
          end
          prep_idx <= prep_idx + NW'(1);
          if (prep_idx == nsyn_q - NW'(1)) begin
            state    <= ST_RUN;
            in_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (xfer) begin
            for (int i = 0; i < int'(NSYN); i++) syn[i] <= syn_nxt[i];
            cnt <= cnt_inc;
            if (term) begin
              in_ready   <= 1'b0;
              done       <= 1'b1;
              len_err    <= len_bad;
              error_free <= all_zero && !len_bad;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
